keycode_fifo_pio: RTL and testbench
===================================

KEYCODE_FIFO_PIO -- requirements
Module: keycode_fifo_pio

Interface
REQ-001 Parameter DATA_W, default 8: keycode width in bits, legal range 1..32.
REQ-002 Parameter DEPTH, default 8: FIFO entries, power of two, legal range 2..1024.
REQ-003 Parameter RESET_VALUE, default 0: reset contents of out_port, DATA_W bits.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 address  in  2  Avalon-MM register select.
REQ-008 chipselect  in  1  Avalon-MM slave select.
REQ-009 write_n  in  1  active-low write strobe, qualified by chipselect.
REQ-010 writedata  in  32  write data.
REQ-011 readdata  out  32  combinational read data, zero-filled above the defined fields.
REQ-012 out_data  out  DATA_W  FIFO head, meaningful only while out_valid is 1.
REQ-013 out_valid  out  1  FIFO non-empty.
REQ-014 out_ready  in  1  consumer accepts head.
REQ-015 out_port  out  DATA_W  last consumed keycode, held (legacy PIO view).
REQ-016 irq  out  1  level interrupt.

Function
REQ-017 Write cycle = chipselect & ~write_n; register offsets: 0 DATA, 1 STATUS, 2 CONTROL, 3 LAST.
REQ-018 Write DATA SHALL push writedata[DATA_W-1:0] at that clock edge; read DATA returns out_data, or 0 when empty.
REQ-019 STATUS read layout SHALL be: [15:0] count; [16] empty; [17] full; [18] overflow (sticky).
REQ-020 Write STATUS with writedata[18]=1 SHALL clear overflow; other bits ignored.
REQ-021 Write CONTROL bit0=1 SHALL flush: count=0, pointers=0, self-clearing, never stored; bit1 SHALL store irq_en; read returns irq_en in bit1, bit0 always 0.
REQ-022 Read LAST SHALL return out_port; write LAST is ignored.
REQ-023 Pop = out_valid & out_ready; at that edge out_port <= out_data and the read pointer advances.
REQ-024 FIFO SHALL be first-word fall-through: a push at edge N makes out_valid=1 and out_data=pushed value immediately after edge N.
REQ-025 Push while full without a simultaneous pop SHALL be dropped, set overflow, and leave contents unchanged.
REQ-026 Push while full with a simultaneous pop SHALL be accepted; count is unchanged.
REQ-027 Push and pop in the same cycle at any other count SHALL leave count unchanged.
REQ-028 Flush in the same cycle as a consumer pop SHALL win: no push or pop takes effect, overflow is not set, out_port is not updated.
REQ-029 Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits; full = (count==DEPTH).
REQ-030 irq SHALL equal irq_en & (overflow | empty), registered-free (combinational from state).
REQ-031 Reads SHALL have no side effects.

Reset
REQ-032 On reset_n=0, asynchronously: count=0, pointers=0, overflow=0, irq_en=0, out_port=RESET_VALUE; hence out_valid=0, irq=0.
REQ-033 FIFO storage SHALL NOT be reset; it is never observable while empty.
REQ-034 Reset mid-operation SHALL discard all queued entries; the first push after reset release behaves as a push into an empty FIFO.

Structure
REQ-035 Shared package pio_pkg SHALL hold the register offsets, the STATUS bit positions (EMPTY=16, FULL=17, OVF=18) and the CONTROL bit positions (FLUSH=0, IRQ_EN=1).
REQ-036 Storage and pointer/count logic SHALL sit in one sub-module, pio_sync_fifo, parametrised by DATA_W and DEPTH.
REQ-037 Register decode, out_port and irq SHALL live in the top level.

Verification (DATA_W=8, DEPTH=4)
REQ-038 Reset release -> out_port=RESET_VALUE, STATUS=0x0001_0000, out_valid=0, irq=0.
REQ-039 Push 0x1C, 0x23; out_ready=0 -> out_valid=1, out_data=0x1C, STATUS count=2; out_ready=1 for 1 cycle -> out_port=0x1C, out_data=0x23.
REQ-040 Push 0x01..0x05, out_ready=0 -> 0x05 dropped, STATUS=0x0006_0004; write STATUS 0x40000 -> STATUS=0x0002_0004.
REQ-041 FIFO full with head 0x01; push 0x09 with out_ready=1 in the same cycle -> count stays 4, out_port=0x01, entry 0x09 is last in order, no overflow.
REQ-042 Three entries queued; write CONTROL=0x3 with out_ready=1 -> count=0, out_port unchanged, CONTROL reads 0x2, irq=1; push 0x44 -> irq=0.
REQ-043 Six push/pop cycles -> pointers wrap past DEPTH and data order is preserved.

Source files
------------

// File: rtl/pio_pkg.sv
// Register map and bit positions shared by the keycode FIFO PIO and its bench.
package pio_pkg;

    typedef enum logic [1:0] {
        REG_DATA    = 2'd0,
        REG_STATUS  = 2'd1,
        REG_CONTROL = 2'd2,
        REG_LAST    = 2'd3
    } reg_sel_e;

    localparam int STAT_EMPTY  = 16;
    localparam int STAT_FULL   = 17;
    localparam int STAT_OVF    = 18;

    localparam int CTRL_FLUSH  = 0;
    localparam int CTRL_IRQ_EN = 1;

endpackage

// File: rtl/keycode_fifo_pio_if.sv
// Avalon-MM slave register bus of the keycode FIFO PIO.
interface keycode_fifo_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport slave  (input address, chipselect, write_n, writedata, output readdata);
    modport master (output address, chipselect, write_n, writedata, input readdata);
endinterface

// File: rtl/pio_sync_fifo.sv
// First-word fall-through FIFO: storage, wrapping pointers and occupancy count.
module pio_sync_fifo #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 8,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count,
    output logic              drop
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop & ~empty & ~flush;
        // When full, a push is only accepted if the head leaves in the same edge.
        do_push  = push & ~flush & (~full | do_pop);
        drop     = push & ~flush & full & ~do_pop;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
            else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never visible while empty, so it carries no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/keycode_fifo_pio.sv
// Keycode FIFO with Avalon-MM register access, streaming head output and legacy PIO view.
module keycode_fifo_pio
    import pio_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                DEPTH       = 8,
    parameter logic [DATA_W-1:0] RESET_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    keycode_fifo_pio_if.slave       bus,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_port,
    output logic                    irq
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    reg_sel_e          sel;
    logic              wr_cyc, push, flush, pop, drop, empty, full;
    logic [CNT_W-1:0]  count;
    logic              ovf_q, ovf_d;
    logic              irq_en_q, irq_en_d;
    logic [DATA_W-1:0] out_port_q, out_port_d;

    assign sel    = reg_sel_e'(bus.address);
    assign wr_cyc = bus.chipselect & ~bus.write_n;
    assign push   = wr_cyc & (sel == REG_DATA);
    assign flush  = wr_cyc & (sel == REG_CONTROL) & bus.writedata[CTRL_FLUSH];
    assign pop    = out_valid & out_ready;

    pio_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (reset_n),
        .push      (push),
        .push_data (bus.writedata[DATA_W-1:0]),
        .pop       (pop),
        .flush     (flush),
        .head      (out_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .drop      (drop)
    );

    assign out_valid = ~empty;
    assign out_port  = out_port_q;
    assign irq       = irq_en_q & (ovf_q | empty);

    always_comb begin
        ovf_d      = ovf_q;
        irq_en_d   = irq_en_q;
        out_port_d = out_port_q;
        if (wr_cyc && sel == REG_STATUS && bus.writedata[STAT_OVF]) ovf_d = 1'b0;
        if (drop) ovf_d = 1'b1;
        if (wr_cyc && sel == REG_CONTROL) irq_en_d = bus.writedata[CTRL_IRQ_EN];
        // A flush cancels the consumer pop, so the PIO view keeps its old value.
        if (pop && !flush) out_port_d = out_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q      <= 1'b0;
            irq_en_q   <= 1'b0;
            out_port_q <= RESET_VALUE;
        end else begin
            ovf_q      <= ovf_d;
            irq_en_q   <= irq_en_d;
            out_port_q <= out_port_d;
        end
    end

    always_comb begin
        bus.readdata = '0;
        case (sel)
            REG_DATA:    bus.readdata = out_valid ? 32'(out_data) : 32'd0;
            REG_STATUS: begin
                bus.readdata[15:0]       = 16'(count);
                bus.readdata[STAT_EMPTY] = empty;
                bus.readdata[STAT_FULL]  = full;
                bus.readdata[STAT_OVF]   = ovf_q;
            end
            REG_CONTROL: bus.readdata[CTRL_IRQ_EN] = irq_en_q;
            REG_LAST:    bus.readdata = 32'(out_port_q);
            default:     bus.readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_keycode_fifo_pio.sv
// Bench for keycode_fifo_pio at DATA_W=8, DEPTH=4: vector table plus data-order scoreboard.
module tb_keycode_fifo_pio;
    import pio_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] out_data, out_port;
    logic       out_valid, out_ready, irq;

    always #5 clk = ~clk;

    keycode_fifo_pio_if bus ();

    keycode_fifo_pio #(.DATA_W(8), .DEPTH(4), .RESET_VALUE(8'hA5)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus.slave),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_port  (out_port),
        .irq       (irq)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic        rdy;
        logic [31:0] st;
        logic        vld;
        logic [7:0]  dat;
        logic [7:0]  port;
        logic        irq;
        logic [31:0] ctrl;
    } vec_t;

    vec_t       vq[$];
    logic [7:0] sb[$];
    int         n_chk  = 0;
    int         n_pass = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", name, got, exp);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        bus.address    = a;
        #1;
        d = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    // One bus/consumer cycle; the scoreboard checks every pop against the push order.
    task automatic cycle(input logic wr, input logic [1:0] addr, input logic [31:0] wd, input logic rdy);
        logic fl, ps, pp;
        @(negedge clk);
        bus.chipselect = wr;
        bus.write_n    = ~wr;
        bus.address    = addr;
        bus.writedata  = wd;
        out_ready      = rdy;
        #1;
        fl = wr && addr == 2'd2 && wd[0];
        ps = wr && addr == 2'd0 && !fl;
        pp = (sb.size() > 0) && rdy && !fl;
        check("sb_valid", 32'(out_valid), 32'(sb.size() != 0));
        if (pp) begin
            check("sb_pop", 32'(out_data), 32'(sb[0]));
            void'(sb.pop_front());
        end
        if (ps && sb.size() < 4) sb.push_back(wd[7:0]);
        if (fl) sb.delete();
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        out_ready      = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        reset_n        = 1'b0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 2'd0;
        bus.writedata  = '0;
        out_ready      = 1'b0;

        vq.push_back('{1'b1, 2'd0, 32'h1C, 1'b0, 32'h1,     1'b1, 8'h1C, 8'hA5, 1'b0, 32'h0});
        vq.push_back('{1'b1, 2'd0, 32'h23, 1'b0, 32'h2,     1'b1, 8'h1C, 8'hA5, 1'b0, 32'h0});
        vq.push_back('{1'b0, 2'd0, 32'h0,  1'b1, 32'h1,     1'b1, 8'h23, 8'h1C, 1'b0, 32'h0});
        vq.push_back('{1'b0, 2'd0, 32'h0,  1'b1, 32'h10000, 1'b0, 8'h00, 8'h23, 1'b0, 32'h0});
        vq.push_back('{1'b1, 2'd0, 32'h01, 1'b0, 32'h1,     1'b1, 8'h01, 8'h23, 1'b0, 32'h0});
        vq.push_back('{1'b1, 2'd0, 32'h02, 1'b0, 32'h2,     1'b1, 8'h01, 8'h23, 1'b0, 32'h0});
        vq.push_back('{1'b1, 2'd0, 32'h03, 1'b0, 32'h3,     1'b1, 8'h01, 8'h23, 1'b0, 32'h0});
        vq.push_back('{1'b1, 2'd0, 32'h04, 1'b0, 32'h20004, 1'b1, 8'h01, 8'h23, 1'b0, 32'h0});
        vq.push_back('{1'b1, 2'd0, 32'h05, 1'b0, 32'h60004, 1'b1, 8'h01, 8'h23, 1'b0, 32'h0});
        vq.push_back('{1'b1, 2'd1, 32'h40000, 1'b0, 32'h20004, 1'b1, 8'h01, 8'h23, 1'b0, 32'h0});
        vq.push_back('{1'b1, 2'd0, 32'h09, 1'b1, 32'h20004, 1'b1, 8'h02, 8'h01, 1'b0, 32'h0});
        vq.push_back('{1'b0, 2'd0, 32'h0,  1'b1, 32'h3,     1'b1, 8'h03, 8'h02, 1'b0, 32'h0});
        vq.push_back('{1'b0, 2'd0, 32'h0,  1'b1, 32'h2,     1'b1, 8'h04, 8'h03, 1'b0, 32'h0});
        vq.push_back('{1'b0, 2'd0, 32'h0,  1'b1, 32'h1,     1'b1, 8'h09, 8'h04, 1'b0, 32'h0});
        vq.push_back('{1'b0, 2'd0, 32'h0,  1'b1, 32'h10000, 1'b0, 8'h00, 8'h09, 1'b0, 32'h0});
        vq.push_back('{1'b1, 2'd0, 32'hA1, 1'b0, 32'h1,     1'b1, 8'hA1, 8'h09, 1'b0, 32'h0});
        vq.push_back('{1'b1, 2'd0, 32'hA2, 1'b0, 32'h2,     1'b1, 8'hA1, 8'h09, 1'b0, 32'h0});
        vq.push_back('{1'b1, 2'd0, 32'hA3, 1'b0, 32'h3,     1'b1, 8'hA1, 8'h09, 1'b0, 32'h0});
        vq.push_back('{1'b1, 2'd2, 32'h3,  1'b1, 32'h10000, 1'b0, 8'h00, 8'h09, 1'b1, 32'h2});
        vq.push_back('{1'b1, 2'd0, 32'h44, 1'b0, 32'h1,     1'b1, 8'h44, 8'h09, 1'b0, 32'h2});
        for (int i = 0; i < 6; i++) begin
            vq.push_back('{1'b1, 2'd0, 32'(8'h50 + i), 1'b1, 32'h1, 1'b1, 8'(8'h50 + i),
                           (i == 0) ? 8'h44 : 8'(8'h4F + i), 1'b0, 32'h2});
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_port", 32'(out_port), 32'hA5);
        check("rst_irq", 32'(irq), 32'h0);
        rd(REG_STATUS, d);  check("rst_status", d, 32'h0001_0000);
        rd(REG_CONTROL, d); check("rst_ctrl", d, 32'h0);
        rd(REG_DATA, d);    check("rst_data_empty", d, 32'h0);
        rd(REG_LAST, d);    check("rst_last", d, 32'hA5);

        for (int i = 0; i < vq.size(); i++) begin
            cycle(vq[i].wr, vq[i].addr, vq[i].wd, vq[i].rdy);
            rd(REG_STATUS, d);  check($sformatf("v%0d_status", i), d, vq[i].st);
            rd(REG_CONTROL, d); check($sformatf("v%0d_ctrl", i), d, vq[i].ctrl);
            check($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vq[i].vld));
            if (vq[i].vld) check($sformatf("v%0d_data", i), 32'(out_data), 32'(vq[i].dat));
            check($sformatf("v%0d_port", i), 32'(out_port), 32'(vq[i].port));
            check($sformatf("v%0d_irq", i), 32'(irq), 32'(vq[i].irq));
        end

        // Reset in the middle of a cycle drops queued entries and registers.
        cycle(1'b1, 2'd0, 32'h61, 1'b0);
        cycle(1'b1, 2'd0, 32'h62, 1'b0);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        check("mid_rst_port", 32'(out_port), 32'hA5);
        check("mid_rst_irq", 32'(irq), 32'h0);
        rd(REG_STATUS, d);  check("mid_rst_status", d, 32'h0001_0000);
        rd(REG_CONTROL, d); check("mid_rst_ctrl", d, 32'h0);
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        cycle(1'b1, 2'd0, 32'h77, 1'b0);
        rd(REG_STATUS, d); check("post_rst_status", d, 32'h1);
        rd(REG_DATA, d);   check("post_rst_data", d, 32'h77);
        cycle(1'b0, 2'd0, 32'h0, 1'b1);
        check("post_rst_port", 32'(out_port), 32'h77);

        // LAST is read-only; DATA reads the head without popping it.
        cycle(1'b1, 2'd3, 32'hFF, 1'b0);
        rd(REG_LAST, d);   check("last_ro", d, 32'h77);
        cycle(1'b1, 2'd0, 32'h3C, 1'b0);
        rd(REG_DATA, d);   check("data_rd1", d, 32'h3C);
        rd(REG_DATA, d);   check("data_rd2", d, 32'h3C);
        rd(REG_STATUS, d); check("data_rd_status", d, 32'h1);
        cycle(1'b0, 2'd0, 32'h0, 1'b1);
        check("final_port", 32'(out_port), 32'h3C);
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
